// File: rtl/dct8_stream.sv
// Streaming 8-point 1-D DCT: buffers one 8-sample vector, computes every coefficient in one
// registered step, then emits the first KEEP coefficients serially with scaling and saturation.
module dct8_stream #(
  parameter int unsigned IN_W     = 8,
  parameter int unsigned OUT_W    = 12,
  parameter int unsigned COEF_W   = 8,
  parameter int unsigned SHIFT    = 3,
  parameter int unsigned DC_EXTRA = 2,
  parameter int unsigned KEEP     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    dc_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic [2:0]              out_idx,
  output logic                    out_last
);

  localparam int unsigned ACC_W = IN_W + COEF_W + 3;
  localparam logic [2:0]  LAST_IDX = 3'(KEEP - 1);

  localparam logic signed [ACC_W-1:0] C1 = ACC_W'(126);
  localparam logic signed [ACC_W-1:0] C2 = ACC_W'(118);
  localparam logic signed [ACC_W-1:0] C3 = ACC_W'(106);
  localparam logic signed [ACC_W-1:0] C4 = ACC_W'(91);
  localparam logic signed [ACC_W-1:0] C5 = ACC_W'(71);
  localparam logic signed [ACC_W-1:0] C6 = ACC_W'(49);
  localparam logic signed [ACC_W-1:0] C7 = ACC_W'(25);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  typedef enum logic [1:0] {FILL, CALC, EMIT} state_t;

  state_t                  state_q;
  logic [2:0]              count_q;
  logic                    dc_q;
  logic signed [IN_W-1:0]  x_q    [8];
  logic signed [OUT_W-1:0] coef_q [8];
  logic signed [OUT_W-1:0] coef_d [8];

  logic signed [ACC_W-1:0] s_w [4];
  logic signed [ACC_W-1:0] d_w [4];
  logic signed [ACC_W-1:0] z_w [8];
  logic signed [ACC_W-1:0] y_w [8];
  logic signed [ACC_W-1:0] e0_w, e1_w, f0_w, f1_w;

  function automatic logic signed [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      return OUT_W'(SAT_MAX);
    else if (v < SAT_MIN) return OUT_W'(SAT_MIN);
    else                  return OUT_W'(v);
  endfunction

  // Butterfly-factored DCT over the buffered vector, then scale and clamp.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      s_w[i] = ACC_W'(x_q[i]) + ACC_W'(x_q[7-i]);
      d_w[i] = ACC_W'(x_q[i]) - ACC_W'(x_q[7-i]);
    end
    e0_w = s_w[0] + s_w[3];
    e1_w = s_w[1] + s_w[2];
    f0_w = s_w[0] - s_w[3];
    f1_w = s_w[1] - s_w[2];

    z_w[0] = C4 * (e0_w + e1_w);
    z_w[4] = C4 * (e0_w - e1_w);
    z_w[2] = C2 * f0_w + C6 * f1_w;
    z_w[6] = C6 * f0_w - C2 * f1_w;
    z_w[1] = C1 * d_w[0] + C3 * d_w[1] + C5 * d_w[2] + C7 * d_w[3];
    z_w[3] = C3 * d_w[0] - C7 * d_w[1] - C1 * d_w[2] - C5 * d_w[3];
    z_w[5] = C5 * d_w[0] - C1 * d_w[1] + C7 * d_w[2] + C3 * d_w[3];
    z_w[7] = C7 * d_w[0] - C5 * d_w[1] + C3 * d_w[2] - C1 * d_w[3];

    for (int k = 0; k < 8; k++) begin
      if (k == 0 && dc_q) y_w[k] = z_w[k] >>> (SHIFT + DC_EXTRA);
      else                y_w[k] = z_w[k] >>> SHIFT;
      coef_d[k] = sat(y_w[k]);
    end
  end

  // Control FSM; sample buffer, dc latch and coefficient bank are deliberately unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      count_q   <= 3'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= 3'd0;
      out_last  <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (in_valid && in_ready) begin
            x_q[count_q] <= in_data;
            if (count_q == 3'd0) dc_q <= dc_mode;
            count_q <= count_q + 3'd1;
            if (count_q == 3'd7) begin
              state_q  <= CALC;
              in_ready <= 1'b0;
            end
          end
        end
        CALC: begin
          for (int k = 0; k < 8; k++) coef_q[k] <= coef_d[k];
          out_data  <= coef_d[0];
          out_idx   <= 3'd0;
          out_last  <= (LAST_IDX == 3'd0);
          out_valid <= 1'b1;
          state_q   <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            if (out_idx == LAST_IDX) begin
              state_q   <= FILL;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              out_idx  <= out_idx + 3'd1;
              out_data <= coef_q[out_idx + 3'd1];
              out_last <= ((out_idx + 3'd1) == LAST_IDX);
            end
          end
        end
        default: begin
          state_q  <= FILL;
          count_q  <= 3'd0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dct8_stream.sv
// Self-checking bench for dct8_stream against a direct cosine-matrix DCT model.
`timescale 1ns/1ps
module tb_dct8_stream;

  localparam int IN_W  = 8;
  localparam int OUT_W = 12;
  localparam int KEEP  = 6;

  typedef int vec_t [8];

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_data;
  logic                    dc_mode;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic [2:0]              out_idx;
  logic                    out_last;

  int checks;
  int errors;

  int got_data [8];
  int got_idx  [8];
  bit got_last [8];
  int got_n;
  int hold_bad;
  int rdy_bad;
  int stall_done;
  int first_valid;
  bit send_timeout;

  dct8_stream #(
    .IN_W(8), .OUT_W(12), .COEF_W(8), .SHIFT(3), .DC_EXTRA(2), .KEEP(6)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .dc_mode(dc_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: y_k = sum_n x_n * Q7 cos((2n+1) k pi / 16), DC term uses cos(pi/4).
  function automatic void model(input vec_t x, input bit dc, output vec_t y);
    int ctab [9];
    int z, m, cv, sh, v;
    ctab = '{128, 126, 118, 106, 91, 71, 49, 25, 0};
    for (int k = 0; k < 8; k++) begin
      z = 0;
      for (int n = 0; n < 8; n++) begin
        m = ((2 * n + 1) * k) % 32;
        if (m > 16) m = 32 - m;
        cv = (m > 8) ? -ctab[16 - m] : ctab[m];
        if (k == 0) cv = 91;
        z += x[n] * cv;
      end
      sh = (k == 0 && dc) ? 5 : 3;
      v = z >>> sh;
      if (v > 2047) v = 2047;
      if (v < -2048) v = -2048;
      y[k] = v;
    end
  endfunction

  task automatic send_block(input vec_t xs, input int nsamp, input bit dc,
                            input bit gaps, input bit toggle_dc);
    int n = 0;
    int cyc = 0;
    int budget = 200;
    while (n < nsamp && budget > 0) begin
      @(negedge clk);
      budget--;
      in_valid = gaps ? ((cyc % 2) == 0) : 1'b1;
      cyc++;
      in_data  = in_valid ? IN_W'(xs[n]) : IN_W'($urandom);
      dc_mode  = (n == 0) ? dc : (toggle_dc ? ~dc : dc);
      if (in_valid && in_ready) n++;
    end
    send_timeout = (n < nsamp);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = IN_W'($urandom);
  endtask

  task automatic collect(input int stall_at, input int stall_len, input bit rand_rdy);
    int budget = 300;
    int cyc = 0;
    bit held = 1'b0;
    int pdata = 0;
    int pidx = 0;
    bit plast = 1'b0;
    got_n = 0; hold_bad = 0; rdy_bad = 0; stall_done = 0; first_valid = -1;
    while (got_n < KEEP && budget > 0) begin
      @(negedge clk);
      budget--;
      cyc++;
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && in_ready) rdy_bad++;
      if (held && (int'(out_data) != pdata || int'(out_idx) != pidx || out_last != plast))
        hold_bad++;
      if (out_valid && int'(out_idx) == stall_at && stall_done < stall_len) begin
        out_ready = 1'b0;
        stall_done++;
      end else if (rand_rdy) begin
        out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        got_data[got_n] = int'(out_data);
        got_idx[got_n]  = int'(out_idx);
        got_last[got_n] = out_last;
        got_n++;
      end
      held  = out_valid && !out_ready;
      pdata = int'(out_data);
      pidx  = int'(out_idx);
      plast = out_last;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 ||
        out_idx !== 3'd0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b out_data=%0d out_idx=%0d out_last=%b, required 1 0 0 0 0",
               in_ready, out_valid, out_data, out_idx, out_last);
    end
    rst = 1'b0;
  endtask

  task automatic test_ramp();
    vec_t ramp, exp;
    ramp = '{0, 1, 2, 3, 4, 5, 6, 7};
    exp  = '{318, -207, 0, -21, 0, -6, 0, 0};
    send_block(ramp, 8, 1'b0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ramp_calc_cycle: out_valid=%b in_ready=%b, required 0 0", out_valid, in_ready);
    end
    collect(-1, 0, 1'b0);
    checks++;
    if (send_timeout || got_n != KEEP) begin
      errors++;
      $display("FAIL ramp_count: got %0d outputs (send_timeout=%b), required %0d", got_n, send_timeout, KEEP);
    end
    checks++;
    if (first_valid != 1) begin
      errors++;
      $display("FAIL ramp_latency: out_valid first seen %0d cycles after calc cycle, required 1", first_valid);
    end
    for (int k = 0; k < got_n; k++) begin
      checks++;
      if (got_data[k] != exp[k] || got_idx[k] != k || got_last[k] != (k == KEEP - 1)) begin
        errors++;
        $display("FAIL ramp_coef%0d: data=%0d idx=%0d last=%b, required %0d %0d %b",
                 k, got_data[k], got_idx[k], got_last[k], exp[k], k, (k == KEEP - 1));
      end
    end
    checks++;
    if (rdy_bad != 0) begin
      errors++;
      $display("FAIL ramp_in_ready_emit: in_ready high in %0d EMIT cycles, required 0", rdy_bad);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ramp_return_fill: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_flat();
    vec_t flat;
    int exp0 [4];
    bit dcs [4];
    bit tog [4];
    flat = '{16, 16, 16, 16, 16, 16, 16, 16};
    exp0 = '{1456, 364, 364, 1456};
    dcs  = '{1'b0, 1'b1, 1'b1, 1'b0};
    tog  = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int t = 0; t < 4; t++) begin
      send_block(flat, 8, dcs[t], 1'b0, tog[t]);
      collect(-1, 0, 1'b0);
      checks++;
      if (send_timeout || got_n != KEEP) begin
        errors++;
        $display("FAIL flat%0d_count: got %0d outputs, required %0d", t, got_n, KEEP);
      end
      for (int k = 0; k < got_n; k++) begin
        checks++;
        if (got_data[k] != ((k == 0) ? exp0[t] : 0) || got_idx[k] != k) begin
          errors++;
          $display("FAIL flat%0d_coef%0d: data=%0d idx=%0d, required %0d %0d",
                   t, k, got_data[k], got_idx[k], (k == 0) ? exp0[t] : 0, k);
        end
      end
    end
  endtask

  task automatic test_saturation();
    vec_t a, b, ea, eb;
    a = '{127, 127, 127, 127, 127, 127, 127, 127};
    b = '{-128, 0, 0, 0, 0, 0, 0, 127};
    model(a, 1'b0, ea);
    model(b, 1'b0, eb);
    send_block(a, 8, 1'b0, 1'b0, 1'b0);
    collect(-1, 0, 1'b0);
    checks++;
    if (got_n != KEEP || got_data[0] != 2047) begin
      errors++;
      $display("FAIL sat_pos_dc: n=%0d data0=%0d, required %0d 2047", got_n, got_data[0], KEEP);
    end
    for (int k = 1; k < got_n; k++) begin
      checks++;
      if (got_data[k] != ea[k]) begin
        errors++;
        $display("FAIL sat_pos_coef%0d: data=%0d, required %0d", k, got_data[k], ea[k]);
      end
    end
    send_block(b, 8, 1'b0, 1'b0, 1'b0);
    collect(-1, 0, 1'b0);
    checks++;
    if (got_n != KEEP || got_data[0] != -12 || got_data[1] != -2048) begin
      errors++;
      $display("FAIL sat_neg: n=%0d data0=%0d data1=%0d, required %0d -12 -2048",
               got_n, got_data[0], got_data[1], KEEP);
    end
    for (int k = 2; k < got_n; k++) begin
      checks++;
      if (got_data[k] != eb[k]) begin
        errors++;
        $display("FAIL sat_neg_coef%0d: data=%0d, required %0d", k, got_data[k], eb[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    vec_t ramp, exp;
    ramp = '{0, 1, 2, 3, 4, 5, 6, 7};
    exp  = '{318, -207, 0, -21, 0, -6, 0, 0};
    send_block(ramp, 8, 1'b0, 1'b0, 1'b0);
    collect(2, 5, 1'b0);
    checks++;
    if (got_n != KEEP || stall_done != 5 || hold_bad != 0 || rdy_bad != 0) begin
      errors++;
      $display("FAIL bp_hold: n=%0d stalls=%0d hold_bad=%0d rdy_bad=%0d, required %0d 5 0 0",
               got_n, stall_done, hold_bad, rdy_bad, KEEP);
    end
    for (int k = 0; k < got_n; k++) begin
      checks++;
      if (got_data[k] != exp[k] || got_idx[k] != k || got_last[k] != (k == KEEP - 1)) begin
        errors++;
        $display("FAIL bp_coef%0d: data=%0d idx=%0d last=%b, required %0d %0d %b",
                 k, got_data[k], got_idx[k], got_last[k], exp[k], k, (k == KEEP - 1));
      end
    end
  endtask

  task automatic test_gaps();
    vec_t ramp, exp;
    ramp = '{0, 1, 2, 3, 4, 5, 6, 7};
    exp  = '{318, -207, 0, -21, 0, -6, 0, 0};
    send_block(ramp, 8, 1'b0, 1'b1, 1'b0);
    collect(-1, 0, 1'b0);
    checks++;
    if (send_timeout || got_n != KEEP) begin
      errors++;
      $display("FAIL gaps_count: got %0d outputs, required %0d", got_n, KEEP);
    end
    for (int k = 0; k < got_n; k++) begin
      checks++;
      if (got_data[k] != exp[k] || got_idx[k] != k) begin
        errors++;
        $display("FAIL gaps_coef%0d: data=%0d idx=%0d, required %0d %0d",
                 k, got_data[k], got_idx[k], exp[k], k);
      end
    end
  endtask

  task automatic test_reset_mid();
    vec_t junk, ramp, exp;
    junk = '{100, -100, 90, -90, 0, 0, 0, 0};
    ramp = '{0, 1, 2, 3, 4, 5, 6, 7};
    exp  = '{318, -207, 0, -21, 0, -6, 0, 0};
    send_block(junk, 4, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_fill: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    send_block(ramp, 8, 1'b0, 1'b0, 1'b0);
    collect(-1, 0, 1'b0);
    checks++;
    if (got_n != KEEP) begin
      errors++;
      $display("FAIL rst_fill_count: got %0d outputs, required %0d", got_n, KEEP);
    end
    for (int k = 0; k < got_n; k++) begin
      checks++;
      if (got_data[k] != exp[k] || got_idx[k] != k) begin
        errors++;
        $display("FAIL rst_fill_coef%0d: data=%0d idx=%0d, required %0d %0d",
                 k, got_data[k], got_idx[k], exp[k], k);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_fill_extra: out_valid=%b after last coefficient, required 0", out_valid);
    end
    send_block(ramp, 8, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== 3'd0 ||
        out_data !== '0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL rst_emit: out_valid=%b in_ready=%b idx=%0d data=%0d last=%b, required 0 1 0 0 0",
               out_valid, in_ready, out_idx, out_data, out_last);
    end
  endtask

  task automatic test_random();
    vec_t x, exp;
    bit dc;
    for (int b = 0; b < 6; b++) begin
      for (int n = 0; n < 8; n++) x[n] = $urandom_range(0, 255) - 128;
      dc = 1'($urandom);
      model(x, dc, exp);
      send_block(x, 8, dc, 1'(b % 2), 1'($urandom));
      collect(-1, 0, 1'b1);
      checks++;
      if (send_timeout || got_n != KEEP || hold_bad != 0) begin
        errors++;
        $display("FAIL rand%0d_flow: n=%0d hold_bad=%0d, required %0d 0", b, got_n, hold_bad, KEEP);
      end
      for (int k = 0; k < got_n; k++) begin
        checks++;
        if (got_data[k] != exp[k] || got_idx[k] != k || got_last[k] != (k == KEEP - 1)) begin
          errors++;
          $display("FAIL rand%0d_coef%0d: data=%0d idx=%0d last=%b, required %0d %0d %b",
                   b, k, got_data[k], got_idx[k], got_last[k], exp[k], k, (k == KEEP - 1));
        end
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    dc_mode   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_ramp();
    test_flat();
    test_saturation();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
